// File: rtl/deadlock_pkg.sv
// Shared deadlock-monitor types and defaults: FSM state encoding, parameter defaults, trace width.
package deadlock_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WATCH  = 2'd1,
        S_REPORT = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    localparam int NUM_MON_DEF = 4;
    localparam int THRESH_DEF  = 256;
    localparam int CNT_W_DEF   = 16;
    localparam int TRACE_W     = 32;

endpackage

// File: rtl/deadlock_persist_cnt.sv
// One saturating persistence counter; hit is combinational and flags the sample that reaches THRESH.
// No backpressure: advance/flush are decided by the controller each cycle.
module deadlock_persist_cnt #(
    parameter int THRESH = 256,
    parameter int CNT_W  = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic flush,
    input  logic advance,
    input  logic blocked,
    output logic hit
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(THRESH);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            cnt <= '0;
        end else if (advance) begin
            if (!blocked)
                cnt <= '0;
            else if (cnt != LIMIT)
                cnt <= cnt + 1'b1;
        end
    end

    // The sample that takes cnt from THRESH-1 to THRESH is the detecting one.
    assign hit = advance && blocked && (cnt >= LIMIT - 1'b1);

endmodule

// File: rtl/deadlock_report_ctrl.sv
// Deadlock detector: flags a monitor blocked for THRESH cycles; report one cycle after the last blocked sample.
// report_valid/report_idx/trace_cycle held until report_ready; optional cycle stamp under DEADLOCK_TRACE_EN.
module deadlock_report_ctrl
    import deadlock_pkg::*;
#(
    parameter int NUM_MON  = NUM_MON_DEF,
    parameter int THRESH   = THRESH_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    localparam int IDX_W   = (NUM_MON > 1) ? $clog2(NUM_MON) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic [NUM_MON-1:0] mon_block,
    input  logic [NUM_MON-1:0] mon_idle,
    input  logic               clear,
    output logic               report_valid,
    input  logic               report_ready,
    output logic [IDX_W-1:0]   report_idx,
    output logic               deadlock,
    output logic [1:0]         state,
    output logic [TRACE_W-1:0] trace_cycle
);

    state_t             cur, nxt;
    logic               watching;
    logic               release_req;
    logic               flush;
    logic               detect;
    logic [NUM_MON-1:0] blocked;
    logic [NUM_MON-1:0] hit;
    logic               hit_any;
    logic [IDX_W-1:0]   hit_idx;

    assign watching    = (cur == S_WATCH) && enable;
    assign release_req = clear && ((cur == S_REPORT) || (cur == S_HOLD));
    assign flush       = release_req || ((cur == S_WATCH) && !enable);
    assign blocked     = mon_block & ~mon_idle;
    assign detect      = (cur == S_WATCH) && (nxt == S_REPORT);
    assign state       = cur;

    for (genvar g = 0; g < NUM_MON; g++) begin : g_cnt
        deadlock_persist_cnt #(
            .THRESH (THRESH),
            .CNT_W  (CNT_W)
        ) u_cnt (
            .clock   (clock),
            .reset   (reset),
            .flush   (flush),
            .advance (watching),
            .blocked (blocked[g]),
            .hit     (hit[g])
        );
    end

    // Descending scan so the lowest hitting index wins.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = NUM_MON - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        nxt = cur;
        case (cur)
            S_IDLE:   if (enable) nxt = S_WATCH;
            S_WATCH: begin
                if (!enable)
                    nxt = S_IDLE;
                else if (hit_any)
                    nxt = S_REPORT;
            end
            S_REPORT: begin
                if (clear)
                    nxt = enable ? S_WATCH : S_IDLE;
                else if (report_ready)
                    nxt = S_HOLD;
            end
            S_HOLD:   if (clear) nxt = enable ? S_WATCH : S_IDLE;
            default:  nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cur          <= S_IDLE;
            report_valid <= 1'b0;
            report_idx   <= '0;
            deadlock     <= 1'b0;
        end else begin
            cur          <= nxt;
            report_valid <= (nxt == S_REPORT);
            deadlock     <= (nxt == S_REPORT) || (nxt == S_HOLD);
            if (detect)
                report_idx <= hit_idx;
        end
    end

`ifdef DEADLOCK_TRACE_EN
    logic [TRACE_W-1:0] cyc_cnt;

    // Stamp is the counter value visible during the first report cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            cyc_cnt     <= '0;
            trace_cycle <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
            if (detect)
                trace_cycle <= cyc_cnt + 1'b1;
        end
    end
`else
    assign trace_cycle = '0;
`endif

endmodule

// File: doc/deadlock_report_ctrl.md
DEADLOCK_REPORT_CTRL -- requirements
Module: deadlock_report_ctrl

Interface
REQ-001 Parameter NUM_MON, default 4: number of monitored sub-instance block signals.
REQ-002 Parameter THRESH, default 256: consecutive blocked cycles that constitute a deadlock, legal range 1..2**CNT_W-1.
REQ-003 Parameter CNT_W, default 16: persistence counter width.
REQ-004 Derived IDX_W = max(1, clog2(NUM_MON)).
REQ-005 Port list (name, direction, width, meaning):
- clock, in, 1: single clock; all logic on its rising edge.
- reset, in, 1: synchronous, active-high reset.
- enable, in, 1: arms watching.
- mon_block, in, NUM_MON: per-monitor block flag.
- mon_idle, in, NUM_MON: per-monitor idle flag.
- clear, in, 1: acknowledge and re-arm.
- report_valid, out, 1: detection report pending.
- report_ready, in, 1: consumer accepts the report.
- report_idx, out, IDX_W: index of the deadlocked monitor.
- deadlock, out, 1: sticky deadlock flag.
- state, out, 2: current FSM state encoding.
- trace_cycle, out, 32: cycle stamp of the detection.

Function
REQ-006 FSM states, fixed encoding: S_IDLE=0, S_WATCH=1, S_REPORT=2, S_HOLD=3.
REQ-007 S_IDLE to S_WATCH when enable=1; every other input is ignored in S_IDLE.
REQ-008 In S_WATCH, a monitor is blocked when mon_block[i]=1 and mon_idle[i]=0 (mon_idle overrides mon_block).
- A blocked monitor's counter cnt[i] increments by 1.
- Any other cycle clears cnt[i] to 0.
REQ-009 cnt[i] saturates at THRESH and never wraps.
REQ-010 Detection occurs when any cnt[i] reaches THRESH, i.e. after THRESH consecutive blocked samples. In the cycle after the THRESH-th blocked sample:
- FSM enters S_REPORT.
- report_valid=1, deadlock=1.
- report_idx holds the detected index.
REQ-011 If several counters reach THRESH in the same cycle, report_idx is the lowest such index.
REQ-012 In S_REPORT:
- report_valid, report_idx and trace_cycle are held stable until report_ready=1.
- The transfer completes in that cycle, and the next state is S_HOLD with report_valid=0.
REQ-013 In S_HOLD, deadlock stays 1 and counters stay frozen until clear=1. clear=1 causes:
- all counters cleared;
- deadlock=0;
- next state S_WATCH if enable=1, else S_IDLE.
REQ-014 clear=1 in S_REPORT aborts the report: report_valid=0 next cycle, and the same transitions as REQ-013 apply. clear takes priority over a simultaneous report_ready.
REQ-015 enable=0 in S_WATCH clears all counters and returns to S_IDLE next cycle. enable has no effect in S_REPORT or S_HOLD.
REQ-016 clear in S_IDLE or S_WATCH has no effect.
REQ-017 THRESH=1: detection occurs in the cycle after the first blocked sample.

Reset
REQ-018 With reset=1 at a clock edge, the block takes these values, regardless of state or in-flight report:
- state=S_IDLE;
- all cnt[i]=0;
- report_valid=0, report_idx=0, deadlock=0;
- trace_cycle=0 and the free-running cycle counter=0.
REQ-019 Reset has priority over every other input, including clear and report_ready.

Configuration
REQ-020 Macro DEADLOCK_TRACE_EN, when defined:
- A 32-bit free-running cycle counter increments every non-reset cycle and wraps from 2**32-1 to 0.
- Its value at the detection cycle is latched into trace_cycle.
- trace_cycle is held until the next detection or reset.
REQ-021 Without DEADLOCK_TRACE_EN, the cycle counter is absent and trace_cycle is constant 0.

Structure
REQ-022 A shared package deadlock_pkg holds:
- the state typedef with the REQ-006 encoding;
- default parameter constants (NUM_MON, THRESH, CNT_W);
- the trace counter width constant (32).
REQ-023 A single sub-module deadlock_persist_cnt implements one saturating persistence counter with a hit output, instantiated NUM_MON times. FSM, priority select and trace logic reside in deadlock_report_ctrl.

Verification
REQ-024 The bench covers the following directed scenarios (parameters NUM_MON=4, THRESH=4 unless stated):
- Persistence: enable=1; mon_block=4'b0100 for 4 cycles, report_ready=0 -> report_valid=1 and report_idx=2 on the following cycle. Report held until report_ready=1, then state=S_HOLD.
- Interruption: mon_block[1] high 3 cycles, low 1 cycle, high 3 cycles -> no report.
- Idle override: mon_block[0]=1 with mon_idle[0]=1 for 10 cycles -> cnt[0] stays 0 and no report.
- Simultaneous: mon_block=4'b1010 from the same cycle -> report_idx=1.
- Abort and reset mid-report: clear=1 together with report_ready=1 in S_REPORT -> deadlock=0 and state=S_WATCH next cycle. Separately, reset=1 in S_REPORT -> all outputs at reset values next cycle.
- Trace, with DEADLOCK_TRACE_EN defined: detection at cycle counter value 37 -> trace_cycle=37. Without the macro, trace_cycle=0 throughout.
